// File: rtl/ball_game_pkg.sv
// Shared definitions for the ball game controller: state codes, default
// geometry and timing, and the tick-counter width helper.
package ball_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_HIT       = 3'd4,
        S_OVER      = 3'd5
    } game_state_t;

    localparam int X_MAX_DEF     = 328;
    localparam int COUNTDOWN_DEF = 64;
    localparam int FREEZE_DEF    = 32;

    // One counter serves both countdown and freeze; it only reaches N-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(COUNTDOWN_DEF, FREEZE_DEF);

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: pulse is high while level is high and was low on
// the previous clock.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/ball_game_ctrl.sv
// Game sequencing FSM: gates ball movement commands, tracks lives, score
// and best score; every game step is paced by the single-cycle tick.
module ball_game_ctrl
    import ball_game_pkg::*;
#(
    parameter int LIVES_INIT      = 3,
    parameter int COUNTDOWN_TICKS = COUNTDOWN_DEF,
    parameter int FREEZE_TICKS    = FREEZE_DEF,
    parameter int X_MAX           = X_MAX_DEF,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic [9:0]         x_ball,
    input  logic               hit,
    output logic               move_left,
    output logic               move_right,
    output logic               pos_reload,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic [2:0]         state,
    output logic               game_over
);

    localparam int                 CNT_W      = cnt_width(COUNTDOWN_TICKS, FREEZE_TICKS);
    localparam logic [CNT_W-1:0]   CD_LAST    = CNT_W'(COUNTDOWN_TICKS - 1);
    localparam logic [CNT_W-1:0]   FRZ_LAST   = CNT_W'(FREEZE_TICKS - 1);
    localparam logic [9:0]         XMAX10     = 10'(X_MAX);
    localparam logic [1:0]         LIVES0     = 2'(LIVES_INIT);
    localparam logic [SCORE_W-1:0] SCORE_FULL = '1;

    game_state_t        cur, nxt;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         lives_n;
    logic [SCORE_W-1:0] score_n, best_n;
    logic               ml_n, mr_n, rl_n, restart;
    logic               start_p, pause_p;

    edge_pulse u_start (.clk(clk), .reset(reset), .level(btn_start), .pulse(start_p));
    edge_pulse u_pause (.clk(clk), .reset(reset), .level(btn_pause), .pulse(pause_p));

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= S_IDLE;
            cnt        <= '0;
            lives      <= '0;
            score      <= '0;
            best       <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            pos_reload <= 1'b0;
        end else begin
            cur        <= nxt;
            cnt        <= cnt_n;
            lives      <= lives_n;
            score      <= score_n;
            best       <= best_n;
            move_left  <= ml_n;
            move_right <= mr_n;
            pos_reload <= rl_n;
        end
    end

    always_comb begin
        nxt     = cur;
        cnt_n   = cnt;
        lives_n = lives;
        score_n = score;
        best_n  = best;
        ml_n    = 1'b0;
        mr_n    = 1'b0;
        rl_n    = 1'b0;
        restart = 1'b0;
        unique case (cur)
            S_IDLE: restart = start_p;
            S_COUNTDOWN: begin
                if (tick) begin
                    if (cnt == CD_LAST) begin
                        nxt   = S_PLAY;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                // A pause edge swallows a coincident tick entirely.
                if (pause_p) begin
                    nxt = S_PAUSE;
                end else if (tick) begin
                    if (hit) begin
                        if (lives == 2'd1) begin
                            lives_n = '0;
                            best_n  = (score > best) ? score : best;
                            nxt     = S_OVER;
                        end else begin
                            lives_n = lives - 2'd1;
                            cnt_n   = '0;
                            nxt     = S_HIT;
                        end
                    end else begin
                        if (score != SCORE_FULL) score_n = score + 1'b1;
                        ml_n = btn_left & ~btn_right & (x_ball != 10'd0);
                        mr_n = btn_right & ~btn_left & (x_ball < XMAX10);
                    end
                end
            end
            S_PAUSE: begin
                if (start_p)      restart = 1'b1;
                else if (pause_p) nxt     = S_PLAY;
            end
            S_HIT: begin
                if (tick) begin
                    if (cnt == FRZ_LAST) begin
                        rl_n  = 1'b1;
                        cnt_n = '0;
                        nxt   = S_COUNTDOWN;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_OVER: restart = start_p;
            default: nxt = S_IDLE;
        endcase
        if (restart) begin
            nxt     = S_COUNTDOWN;
            cnt_n   = '0;
            lives_n = LIVES0;
            score_n = '0;
            rl_n    = 1'b1;
        end
    end

    assign state     = cur;
    assign game_over = (cur == S_OVER);

endmodule
